// File: rtl/mem_sp_pkg.sv
// mem_sp_pkg: shared definitions for the single-port memory controller.
//   RW_READ / RW_WRITE : request direction encoding (1 = read, 0 = write).
//   state_e            : controller FSM states (INIT clear sweep, RUN service).
//   be_merge()         : byte-lane merge helper for monitors and models that
//                        need the written-word result of a strobed write.
package mem_sp_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Widest word the merge helper handles; narrower callers zero-extend.
    localparam int BE_MERGE_MAX_W = 256;

    // Byte i of the result comes from wdata when be[i] is set, otherwise
    // from old_word.
    function automatic logic [BE_MERGE_MAX_W-1:0] be_merge(
        input logic [BE_MERGE_MAX_W-1:0]   old_word,
        input logic [BE_MERGE_MAX_W-1:0]   wdata,
        input logic [BE_MERGE_MAX_W/8-1:0] be
    );
        logic [BE_MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_MERGE_MAX_W / 8; i++) begin
            if (be[i]) begin
                res[i*8 +: 8] = wdata[i*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_sp_array.sv
// mem_sp_array: pure single-port storage, one byte-wide array per lane so
// byte-enable writes map onto block RAM write enables.
// Ports:
//   clk, rst         clock, synchronous active-high reset (read register only)
//   we, be, addr     write strobe, per-byte enables, word address
//   wdata            write data
//   re               read strobe; rdata loads mem[addr] at the edge
//   rdata            registered read data, holds between reads
module mem_sp_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 65536,
    parameter int AW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [DATA_W/8-1:0] be,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    output logic [DATA_W-1:0]   rdata
);

    localparam int NB = DATA_W / 8;

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rd_q;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                lane_mem[addr] <= wdata[gi*8 +: 8];
            end
        end

        // Output register reset only; the array contents are not reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_rd_q <= '0;
            end else if (re) begin
                lane_rd_q <= lane_mem[addr];
            end
        end

        assign rdata[gi*8 +: 8] = lane_rd_q;
    end

endmodule

// File: rtl/mem_sp_ctrl.sv
// mem_sp_ctrl: single-port synchronous RAM behind a valid/ready request port.
// Optional build macro: MEM_SP_TRACE_EN adds the trc_* request trace outputs.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in RUN)
//   req_rw                   1 = read, 0 = write
//   req_addr, req_wdata      word address, write data
//   req_be                   byte enables (writes only)
//   rsp_valid                one-cycle pulse per accepted read, RD_LAT cycles
//                            after the accepting cycle
//   rsp_rdata, rsp_addr      read data / address, held between responses
//   rsp_err                  with rsp_valid: read address was >= DEPTH
//   wr_err                   pulse: accepted write address was >= DEPTH
//   init_busy                high during the post-reset clear sweep
//   trc_*                    (MEM_SP_TRACE_EN) registered copy of each
//                            accepted request; trc_valid pulses
module mem_sp_ctrl
    import mem_sp_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 16,
    parameter int DEPTH        = 65536,
    parameter int RD_LAT       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_rw,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [ADDR_W-1:0]   rsp_addr,
    output logic                rsp_err,
    output logic                wr_err,
    output logic                init_busy
`ifdef MEM_SP_TRACE_EN
    ,
    output logic                trc_valid,
    output logic                trc_rw,
    output logic [ADDR_W-1:0]   trc_addr,
    output logic [DATA_W-1:0]   trc_wdata
`endif
);

    localparam int NB     = DATA_W / 8;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W is representable and no address
    // ever compares as out of range in that configuration.
    localparam logic [ADDR_W:0]  DEPTH_X    = (ADDR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q;
    logic               wr_err_q;

    logic               accept;
    logic               is_read;
    logic               is_write;
    logic               in_range;

    logic               arr_we;
    logic [NB-1:0]      arr_be;
    logic [MEM_AW-1:0]  arr_addr;
    logic [DATA_W-1:0]  arr_wdata;
    logic               arr_re;
    logic [DATA_W-1:0]  arr_rdata;

    // First read stage: aligned with the array's registered output.
    logic               rd_v1_q;
    logic               rd_err1_q;
    logic [ADDR_W-1:0]  rd_addr1_q;
    logic [DATA_W-1:0]  s1_rdata;

    assign accept   = req_valid && ready_q;
    assign is_read  = accept && (req_rw == RW_READ);
    assign is_write = accept && (req_rw == RW_WRITE);
    assign in_range = ({1'b0, req_addr} < DEPTH_X);

    // ------------------------------------------------------------------
    // FSM next state and array port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arr_we    = 1'b0;
        arr_be    = '0;
        arr_addr  = '0;
        arr_wdata = '0;
        arr_re    = 1'b0;
        unique case (state_q)
            INIT: begin
                // Zero one word per cycle; the request port is closed.
                arr_we   = 1'b1;
                arr_be   = '1;
                arr_addr = cnt_q[MEM_AW-1:0];
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == SWEEP_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Out-of-range requests never touch the array.
                arr_we    = is_write && in_range;
                arr_be    = req_be;
                arr_addr  = req_addr[MEM_AW-1:0];
                arr_wdata = req_wdata;
                arr_re    = is_read && in_range;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RST != 0) ? INIT : RUN;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_v1_q    <= 1'b0;
            rd_err1_q  <= 1'b0;
            rd_addr1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Registered from next state so ready opens together with RUN.
            ready_q  <= (state_d == RUN);
            wr_err_q <= is_write && !in_range;
            rd_v1_q  <= is_read;
            if (is_read) begin
                rd_addr1_q <= req_addr;
                rd_err1_q  <= !in_range;
            end
        end
    end

    mem_sp_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (MEM_AW)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (arr_we),
        .be     (arr_be),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .re     (arr_re),
        .rdata  (arr_rdata)
    );

    // The array output only reloads on in-range reads and rd_err1_q only
    // changes on reads, so this mux holds its value between responses.
    assign s1_rdata = rd_err1_q ? '0 : arr_rdata;

    // ------------------------------------------------------------------
    // Response latency
    // ------------------------------------------------------------------
    if (RD_LAT == 2) begin : g_lat2
        logic               rd_v2_q;
        logic               rd_err2_q;
        logic [ADDR_W-1:0]  rd_addr2_q;
        logic [DATA_W-1:0]  rd_data2_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_v2_q    <= 1'b0;
                rd_err2_q  <= 1'b0;
                rd_addr2_q <= '0;
                rd_data2_q <= '0;
            end else begin
                rd_v2_q <= rd_v1_q;
                if (rd_v1_q) begin
                    rd_err2_q  <= rd_err1_q;
                    rd_addr2_q <= rd_addr1_q;
                    rd_data2_q <= s1_rdata;
                end
            end
        end

        assign rsp_valid = rd_v2_q;
        assign rsp_err   = rd_v2_q && rd_err2_q;
        assign rsp_addr  = rd_addr2_q;
        assign rsp_rdata = rd_data2_q;
    end else begin : g_lat1
        assign rsp_valid = rd_v1_q;
        assign rsp_err   = rd_v1_q && rd_err1_q;
        assign rsp_addr  = rd_addr1_q;
        assign rsp_rdata = s1_rdata;
    end

    assign req_ready = ready_q;
    assign wr_err    = wr_err_q;
    assign init_busy = (state_q == INIT);

`ifdef MEM_SP_TRACE_EN
    // ------------------------------------------------------------------
    // Request trace: accept is only possible in RUN, so INIT never traces.
    // ------------------------------------------------------------------
    logic               trc_valid_q;
    logic               trc_rw_q;
    logic [ADDR_W-1:0]  trc_addr_q;
    logic [DATA_W-1:0]  trc_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trc_valid_q <= 1'b0;
            trc_rw_q    <= 1'b0;
            trc_addr_q  <= '0;
            trc_wdata_q <= '0;
        end else begin
            trc_valid_q <= accept;
            if (accept) begin
                trc_rw_q    <= req_rw;
                trc_addr_q  <= req_addr;
                trc_wdata_q <= req_wdata;
            end
        end
    end

    assign trc_valid = trc_valid_q;
    assign trc_rw    = trc_rw_q;
    assign trc_addr  = trc_addr_q;
    assign trc_wdata = trc_wdata_q;
`endif

endmodule

// File: doc/mem_sp_ctrl.md
Name: mem_sp_ctrl

Overview:
Parametrised single-port synchronous RAM with a valid/ready request interface, byte-lane write strobes, configurable read latency and a post-reset clear sweep. It is the next generation of the 16-bit rw-controlled memory and uses the same rw encoding: 1 = read, 0 = write. It sits between a bus master (CPU/testbench driver) and on-chip storage.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8.
ADDR_W, 16, address width.
DEPTH, 65536, number of implemented words; must be ≤ 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values are 1 or 2.
CLEAR_ON_RST, 1, when 1, zero-fill all DEPTH words after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables; ignored on reads.
- rsp_valid  out  1  one-cycle pulse per accepted read.
- rsp_rdata  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  address of the returned read.
- rsp_err  out  1  qualifies rsp_valid; the read address was ≥ DEPTH.
- wr_err  out  1  one-cycle pulse; an accepted write had address ≥ DEPTH.
- init_busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (rst high at a clock edge):
  - state ← INIT (CLEAR_ON_RST=1) or RUN (CLEAR_ON_RST=0).
  - Sweep counter ← 0.
  - req_ready, rsp_valid, rsp_err, wr_err ← 0; rsp_rdata, rsp_addr ← 0.
  - init_busy ← CLEAR_ON_RST.
  - The read pipeline is flushed; in-flight reads produce no response.
  - Memory contents are not reset, other than by the sweep.
- FSM state INIT:
  - Writes 0 to address = counter each cycle; counter increments.
  - After writing DEPTH-1, goes to RUN; the sweep takes DEPTH cycles.
  - req_ready = 0 throughout. Reset asserted mid-sweep restarts the sweep at 0.
- FSM state RUN:
  - req_ready = 1 every cycle; one operation per cycle; no response backpressure.
- Write (accepted, req_rw=0):
  - For each i with req_be[i]=1: mem[addr] byte i ← wdata byte i at the same edge. Bytes with req_be[i]=0 are unchanged.
  - req_be=0 is a legal no-op.
- Read (accepted, req_rw=1):
  - rsp_valid rises exactly RD_LAT cycles after the accept edge, lasts one cycle, and carries rsp_rdata/rsp_addr.
  - Back-to-back reads give back-to-back responses, in order.
- Ordering: a read accepted the cycle after a write to the same address returns the new data. A read never observes a write accepted later.
- Out-of-range (addr ≥ DEPTH):
  - Write: dropped; wr_err pulses the cycle after the accept.
  - Read: rsp_rdata = 0 and rsp_err = 1 with its rsp_valid.
- Address arithmetic: the sweep counter is $clog2(DEPTH)+1 bits, with no wrap. Request addresses never wrap.
- Output registers hold their last value when not valid, except the pulse outputs, which return to 0.

Optional Feature:
MEM_SP_TRACE_EN.
- Defined: adds outputs trc_valid (1), trc_rw (1), trc_addr (ADDR_W) and trc_wdata (DATA_W), registered one cycle after every accepted request (reads and writes) and never during INIT. trc_valid pulses; the other trace fields hold their value. All are reset to 0. These outputs feed the scoreboard monitor.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_sp_pkg:
  - RW_READ=1'b1 and RW_WRITE=1'b0.
  - State enum typedef {INIT, RUN}.
  - Function be_merge(old, wdata, be) for byte-lane merging.
- Sub-module mem_sp_array: the pure storage array (one port; we/be/addr/wdata; registered rdata).
  - mem_sp_ctrl owns the FSM, sweep, range check, latency pipeline and error/trace logic.

Test Plan:
- Reset with CLEAR_ON_RST=1, DEPTH=16 → init_busy high for 16 cycles, req_ready=0; afterwards, reads of addr 0..15 return 0x0000.
- Write addr 3 = 0xABCD with be=2'b11, then read addr 3 the next cycle → rsp_valid RD_LAT cycles after the read accept; rsp_rdata=0xABCD, rsp_addr=3.
- Write 0x1234 to addr 5, then write 0xFF00 with be=2'b10 → read returns 0xFF34. Repeat with be=2'b00 → still 0xFF34.
- DEPTH=16: write addr 20 → wr_err pulses and memory is unchanged; read addr 20 → rsp_rdata=0, rsp_err=1.
- RD_LAT=2: reads of addr 1,2,3 on consecutive cycles → three consecutive rsp_valid pulses, in order; assert rst between the 2nd and 3rd response → no further rsp_valid and the sweep restarts.
- MEM_SP_TRACE_EN defined: write addr 7 = 0x0042 → next cycle trc_valid=1, trc_rw=0, trc_addr=7, trc_wdata=0x0042.
